// File: rtl/afp3_actag_chk_pkg.sv
// ---------------------------------------------------------------------------
// afp3_actag_chk_pkg
// Shared definitions for the acTag checker: command opcodes the checker
// recognises, the error codes it reports, the capture FSM state type and
// the stage-0 command record.
// ---------------------------------------------------------------------------
package afp3_actag_chk_pkg;

  localparam logic [7:0] ASSIGN_ACTAG = 8'h50;
  localparam logic [7:0] RD_WNITC     = 8'h10;
  localparam logic [7:0] PR_RD_WNITC  = 8'h12;
  localparam logic [7:0] DMA_W        = 8'h20;
  localparam logic [7:0] DMA_W_BE     = 8'h28;
  localparam logic [7:0] DMA_PR_W     = 8'h30;
  localparam logic [7:0] INTRP_REQ    = 8'h58;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_UNASSIGNED = 2'b01;
  localparam logic [1:0] ERR_RANGE      = 2'b10;

  typedef enum logic {
    CAP_ARMED = 1'b0,
    CAP_HELD  = 1'b1
  } cap_state_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [11:0] actag;
    logic [15:0] bdf;
    logic [19:0] pasid;
  } cmd_t;

  // True for every opcode that carries an acTag which must resolve
  // through the table (everything except the assign itself).
  function automatic logic is_use_op(input logic [7:0] op);
    logic w_use;
    w_use = 1'b0;
    case (op)
      RD_WNITC, PR_RD_WNITC, DMA_W, DMA_W_BE, DMA_PR_W, INTRP_REQ: w_use = 1'b1;
      default: w_use = 1'b0;
    endcase
    return w_use;
  endfunction

endpackage

// File: rtl/afp3_actag_chk_if.sv
// ---------------------------------------------------------------------------
// afp3_actag_chk_if
// AFU->TLX command bus as seen after command arbitration.
//   afu_tlx_cmd_valid   one-cycle command strobe, no backpressure
//   afu_tlx_cmd_opcode  command opcode
//   afu_tlx_cmd_actag   acTag field
//   afu_tlx_cmd_bdf     BDF field (meaningful on assign only)
//   afu_tlx_cmd_pasid   PASID field (meaningful on assign only)
// master drives the bus (AFU side), slave observes it (checker side).
// ---------------------------------------------------------------------------
interface afp3_actag_chk_if;
  import afp3_actag_chk_pkg::*;

  logic        afu_tlx_cmd_valid;
  logic [7:0]  afu_tlx_cmd_opcode;
  logic [11:0] afu_tlx_cmd_actag;
  logic [15:0] afu_tlx_cmd_bdf;
  logic [19:0] afu_tlx_cmd_pasid;

  modport master (
    output afu_tlx_cmd_valid,
    output afu_tlx_cmd_opcode,
    output afu_tlx_cmd_actag,
    output afu_tlx_cmd_bdf,
    output afu_tlx_cmd_pasid
  );

  modport slave (
    input afu_tlx_cmd_valid,
    input afu_tlx_cmd_opcode,
    input afu_tlx_cmd_actag,
    input afu_tlx_cmd_bdf,
    input afu_tlx_cmd_pasid
  );

endinterface

// File: rtl/afp3_actag_chk_errcap.sv
// ---------------------------------------------------------------------------
// afp3_actag_chk_errcap
// Saturating error counter plus first-error capture FSM.
//   clock, reset      sole clock, synchronous active-high reset
//   i_err             error pulse from the lookup stage
//   i_err_code        code of that error
//   i_opcode, i_actag command that caused it
//   i_err_clr         MMIO pulse: zero counter and rearm capture
//   o_err_cnt         saturating error count
//   o_cap_held        capture holds an error
//   o_cap_opcode/o_cap_actag/o_cap_code  captured first error
// ---------------------------------------------------------------------------
module afp3_actag_chk_errcap
  import afp3_actag_chk_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_err,
  input  logic [1:0]       i_err_code,
  input  logic [7:0]       i_opcode,
  input  logic [11:0]      i_actag,
  input  logic             i_err_clr,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_cap_held,
  output logic [7:0]       o_cap_opcode,
  output logic [11:0]      o_cap_actag,
  output logic [1:0]       o_cap_code
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  cap_state_t       r_state;
  cap_state_t       w_state_next;
  logic             w_capture;
  logic [CNT_W-1:0] r_err_cnt;
  logic [7:0]       r_cap_opcode;
  logic [11:0]      r_cap_actag;
  logic [1:0]       r_cap_code;

  // Next-state logic. The clear is applied first, so an error arriving in
  // the same cycle as the clear sees an armed FSM and gets captured.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    if (i_err_clr) begin
      w_state_next = CAP_ARMED;
    end
    if (i_err && (i_err_clr || (r_state == CAP_ARMED))) begin
      w_capture    = 1'b1;
      w_state_next = CAP_HELD;
    end
  end

  // Capture state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= CAP_ARMED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Captured error fields; a rearm wipes them so a stale capture is never
  // mistaken for a fresh one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cap_opcode <= '0;
      r_cap_actag  <= '0;
      r_cap_code   <= ERR_NONE;
    end else if (w_capture) begin
      r_cap_opcode <= i_opcode;
      r_cap_actag  <= i_actag;
      r_cap_code   <= i_err_code;
    end else if (i_err_clr) begin
      r_cap_opcode <= '0;
      r_cap_actag  <= '0;
      r_cap_code   <= ERR_NONE;
    end
  end

  // Saturating error counter. A clear coincident with an error leaves the
  // count at one because that error is counted after the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (i_err_clr) begin
      r_err_cnt <= {{(CNT_W-1){1'b0}}, i_err};
    end else if (i_err && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + CNT_ONE;
    end
  end

  assign o_err_cnt    = r_err_cnt;
  assign o_cap_held   = (r_state == CAP_HELD);
  assign o_cap_opcode = r_cap_opcode;
  assign o_cap_actag  = r_cap_actag;
  assign o_cap_code   = r_cap_code;

endmodule

// File: rtl/afp3_actag_chk.sv
// ---------------------------------------------------------------------------
// afp3_actag_chk
// Receiving-end model of the AFU assign-acTag protocol. Assign commands load
// an acTag table with BDF/PASID; later acTag-bearing commands are resolved
// through it and bad acTags are flagged, counted and captured.
//   clock, reset          sole clock, synchronous active-high reset
//   cfg_afu_actag_base    first acTag owned by the AFU (registered)
//   cmd_if                AFU->TLX command bus (slave view)
//   mmio_chk_table_clr    pulse: invalidate the whole table
//   mmio_chk_err_clr      pulse: zero counter, rearm capture
//   chk_valid/bdf/pasid   lookup result of a use command
//   chk_err/chk_err_code  error pulse and its code
//   chk_reassign          an assign overwrote a valid entry
//   chk_err_cnt, chk_cap_* error counter and first-error capture
// Two stages: stage 0 registers the command, stage 1 decodes, accesses the
// table and registers every chk_* output.
// ---------------------------------------------------------------------------
module afp3_actag_chk
  import afp3_actag_chk_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [11:0]      cfg_afu_actag_base,
  afp3_actag_chk_if.slave  cmd_if,
  input  logic             mmio_chk_table_clr,
  input  logic             mmio_chk_err_clr,
  output logic             chk_valid,
  output logic [15:0]      chk_bdf,
  output logic [19:0]      chk_pasid,
  output logic             chk_err,
  output logic [1:0]       chk_err_code,
  output logic             chk_reassign,
  output logic [CNT_W-1:0] chk_err_cnt,
  output logic             chk_cap_held,
  output logic [7:0]       chk_cap_opcode,
  output logic [11:0]      chk_cap_actag,
  output logic [1:0]       chk_cap_code
);

  localparam int          IDX_W       = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [11:0] ENTRIES_LIM = 12'(ENTRIES);

  logic               r_s0_valid;
  cmd_t               r_s0_cmd;
  logic [11:0]        r_base_q;

  logic [ENTRIES-1:0] r_tbl_valid;
  logic [15:0]        r_tbl_bdf   [ENTRIES];
  logic [19:0]        r_tbl_pasid [ENTRIES];
  logic [ENTRIES-1:0] w_tbl_valid_next;

  logic               w_is_assign;
  logic               w_is_use;
  logic [11:0]        w_index;
  logic               w_in_range;
  logic [IDX_W-1:0]   w_addr;
  logic               w_hit_valid;
  logic               w_write;
  logic               w_reassign;
  logic               w_err;
  logic [1:0]         w_err_code;
  logic [15:0]        w_bdf;
  logic [19:0]        w_pasid;

  // Stage 0 valid and AFU base. The base is only allowed to move while the
  // bus is idle, so a single register stage is enough to keep lookups stable.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s0_valid <= 1'b0;
      r_base_q   <= '0;
    end else begin
      r_s0_valid <= cmd_if.afu_tlx_cmd_valid;
      r_base_q   <= cfg_afu_actag_base;
    end
  end

  // Stage 0 command payload; it is qualified by r_s0_valid so it needs no reset.
  always_ff @(posedge clock) begin
    r_s0_cmd <= '{opcode: cmd_if.afu_tlx_cmd_opcode,
                  actag:  cmd_if.afu_tlx_cmd_actag,
                  bdf:    cmd_if.afu_tlx_cmd_bdf,
                  pasid:  cmd_if.afu_tlx_cmd_pasid};
  end

  // Stage 1 decode and lookup. The index is a 12-bit modular distance from
  // the base, so acTags below the base wrap to large values and fall out of
  // range naturally.
  always_comb begin
    w_is_assign = r_s0_valid && (r_s0_cmd.opcode == ASSIGN_ACTAG);
    w_is_use    = r_s0_valid && is_use_op(r_s0_cmd.opcode);
    w_index     = r_s0_cmd.actag - r_base_q;
    w_in_range  = (w_index < ENTRIES_LIM);
    w_addr      = w_index[IDX_W-1:0];
    w_hit_valid = r_tbl_valid[w_addr];
    w_write     = 1'b0;
    w_reassign  = 1'b0;
    w_err       = 1'b0;
    w_err_code  = ERR_NONE;
    w_bdf       = '0;
    w_pasid     = '0;
    if (w_is_assign) begin
      if (w_in_range) begin
        w_write    = 1'b1;
        w_reassign = w_hit_valid;
      end else begin
        w_err      = 1'b1;
        w_err_code = ERR_RANGE;
      end
    end else if (w_is_use) begin
      if (!w_in_range) begin
        w_err      = 1'b1;
        w_err_code = ERR_RANGE;
      end else if (!w_hit_valid) begin
        w_err      = 1'b1;
        w_err_code = ERR_UNASSIGNED;
      end else begin
        w_bdf      = r_tbl_bdf[w_addr];
        w_pasid    = r_tbl_pasid[w_addr];
      end
    end
  end

  // Next valid vector. The table clear wipes everything first and the
  // assign written in the same cycle is then set, so it survives the clear.
  always_comb begin
    w_tbl_valid_next = r_tbl_valid;
    if (mmio_chk_table_clr) begin
      w_tbl_valid_next = '0;
    end
    if (w_write) begin
      w_tbl_valid_next[w_addr] = 1'b1;
    end
  end

  // Table valid bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tbl_valid <= '0;
    end else begin
      r_tbl_valid <= w_tbl_valid_next;
    end
  end

  // Table payload is not reset; the write is suppressed during reset so a
  // command caught mid-flight leaves no trace.
  always_ff @(posedge clock) begin
    if (w_write && !reset) begin
      r_tbl_bdf[w_addr]   <= r_s0_cmd.bdf;
      r_tbl_pasid[w_addr] <= r_s0_cmd.pasid;
    end
  end

  // Stage 1 output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      chk_valid    <= 1'b0;
      chk_bdf      <= '0;
      chk_pasid    <= '0;
      chk_err      <= 1'b0;
      chk_err_code <= ERR_NONE;
      chk_reassign <= 1'b0;
    end else begin
      chk_valid    <= w_is_use;
      chk_bdf      <= w_bdf;
      chk_pasid    <= w_pasid;
      chk_err      <= w_err;
      chk_err_code <= w_err_code;
      chk_reassign <= w_reassign;
    end
  end

  // Counter and capture update on the same edge as the chk_err register.
  afp3_actag_chk_errcap #(
    .CNT_W (CNT_W)
  ) u_errcap (
    .clock        (clock),
    .reset        (reset),
    .i_err        (w_err),
    .i_err_code   (w_err_code),
    .i_opcode     (r_s0_cmd.opcode),
    .i_actag      (r_s0_cmd.actag),
    .i_err_clr    (mmio_chk_err_clr),
    .o_err_cnt    (chk_err_cnt),
    .o_cap_held   (chk_cap_held),
    .o_cap_opcode (chk_cap_opcode),
    .o_cap_actag  (chk_cap_actag),
    .o_cap_code   (chk_cap_code)
  );

endmodule

// File: tb/tb_afp3_actag_chk.sv
// ---------------------------------------------------------------------------
// tb_afp3_actag_chk
// Bench for afp3_actag_chk (ENTRIES 16, CNT_W 4). A cycle-level reference
// model keeps the acTag table as plain arrays keyed by (acTag - base) mod 4096
// and predicts every chk_* output; directed scenarios also check fixed values.
// ---------------------------------------------------------------------------
module tb_afp3_actag_chk;

  localparam int ENTRIES_TB = 16;
  localparam int CNT_W_TB   = 4;

  logic        clock;
  logic        reset;
  logic [11:0] cfgBase;
  logic        tblClr;
  logic        errClr;

  logic                chk_valid;
  logic [15:0]         chk_bdf;
  logic [19:0]         chk_pasid;
  logic                chk_err;
  logic [1:0]          chk_err_code;
  logic                chk_reassign;
  logic [CNT_W_TB-1:0] chk_err_cnt;
  logic                chk_cap_held;
  logic [7:0]          chk_cap_opcode;
  logic [11:0]         chk_cap_actag;
  logic [1:0]          chk_cap_code;

  int testCount;
  int failCount;

  afp3_actag_chk_if cmdIf ();

  afp3_actag_chk #(
    .ENTRIES (ENTRIES_TB),
    .CNT_W   (CNT_W_TB)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .cfg_afu_actag_base (cfgBase),
    .cmd_if             (cmdIf),
    .mmio_chk_table_clr (tblClr),
    .mmio_chk_err_clr   (errClr),
    .chk_valid          (chk_valid),
    .chk_bdf            (chk_bdf),
    .chk_pasid          (chk_pasid),
    .chk_err            (chk_err),
    .chk_err_code       (chk_err_code),
    .chk_reassign       (chk_reassign),
    .chk_err_cnt        (chk_err_cnt),
    .chk_cap_held       (chk_cap_held),
    .chk_cap_opcode     (chk_cap_opcode),
    .chk_cap_actag      (chk_cap_actag),
    .chk_cap_code       (chk_cap_code)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model state: table, base as the checker sees it, the command
  // waiting one cycle before lookup, and the error bookkeeping.
  logic        mValid [ENTRIES_TB];
  logic [15:0] mBdf   [ENTRIES_TB];
  logic [19:0] mPasid [ENTRIES_TB];
  logic [11:0] mBase;
  logic        pV;
  logic [7:0]  pOp;
  logic [11:0] pTag;
  logic [15:0] pBdf;
  logic [19:0] pPasid;
  int          mCnt;
  logic        mHeld;
  logic [7:0]  mCapOp;
  logic [11:0] mCapTag;
  logic [1:0]  mCapCode;
  logic [40:0] expResult;
  logic [26:0] expStatus;

  function automatic logic isUseOp(input logic [7:0] op);
    return (op == 8'h10) || (op == 8'h12) || (op == 8'h20) ||
           (op == 8'h28) || (op == 8'h30) || (op == 8'h58);
  endfunction

  function automatic logic [40:0] actualResult();
    return {chk_valid, chk_err, chk_err_code, chk_reassign, chk_bdf, chk_pasid};
  endfunction

  function automatic logic [26:0] actualStatus();
    return {chk_err_cnt, chk_cap_held, chk_cap_opcode, chk_cap_actag, chk_cap_code};
  endfunction

  // Advance the model by one clock: the previously issued command is looked
  // up, then the table clear, then that command's write, then counters.
  task automatic modelCycle(input logic v, input logic [7:0] op, input logic [11:0] tag,
                            input logic [15:0] bdf, input logic [19:0] pasid,
                            input logic tclr, input logic eclr, input logic rst);
    logic [11:0] idx;
    logic        inRange;
    logic        doWrite;
    logic        eV, eErr, eRe;
    logic [1:0]  eCode;
    logic [15:0] eBdf;
    logic [19:0] ePasid;
    if (rst) begin
      for (int i = 0; i < ENTRIES_TB; i++) mValid[i] = 1'b0;
      mBase = '0; pV = 1'b0; mCnt = 0; mHeld = 1'b0;
      mCapOp = '0; mCapTag = '0; mCapCode = '0;
      expResult = '0;
    end else begin
      eV = 0; eErr = 0; eRe = 0; eCode = 0; eBdf = 0; ePasid = 0; doWrite = 0;
      idx = pTag - mBase;
      inRange = (idx < 12'd16);
      if (pV && pOp == 8'h50) begin
        if (inRange) begin doWrite = 1; eRe = mValid[idx[3:0]]; end
        else begin eErr = 1; eCode = 2'b10; end
      end else if (pV && isUseOp(pOp)) begin
        eV = 1;
        if (!inRange) begin eErr = 1; eCode = 2'b10; end
        else if (!mValid[idx[3:0]]) begin eErr = 1; eCode = 2'b01; end
        else begin eBdf = mBdf[idx[3:0]]; ePasid = mPasid[idx[3:0]]; end
      end
      if (tclr) for (int i = 0; i < ENTRIES_TB; i++) mValid[i] = 1'b0;
      if (doWrite) begin
        mValid[idx[3:0]] = 1'b1; mBdf[idx[3:0]] = pBdf; mPasid[idx[3:0]] = pPasid;
      end
      if (eclr) begin mCnt = 0; mHeld = 0; mCapOp = 0; mCapTag = 0; mCapCode = 0; end
      if (eErr) begin
        if (mCnt < 15) mCnt++;
        if (!mHeld) begin mHeld = 1; mCapOp = pOp; mCapTag = pTag; mCapCode = eCode; end
      end
      expResult = {eV, eErr, eCode, eRe, eBdf, ePasid};
      mBase = cfgBase;
      pV = v; pOp = op; pTag = tag; pBdf = bdf; pPasid = pasid;
    end
    expStatus = {4'(mCnt), mHeld, mCapOp, mCapTag, mCapCode};
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model and
  // return just after the next rising edge, where outputs are sampled.
  task automatic applyStimulus(input logic v, input logic [7:0] op, input logic [11:0] tag,
                               input logic [15:0] bdf, input logic [19:0] pasid,
                               input logic tclr, input logic eclr, input logic rst);
    @(negedge clock);
    cmdIf.afu_tlx_cmd_valid  = v;
    cmdIf.afu_tlx_cmd_opcode = op;
    cmdIf.afu_tlx_cmd_actag  = tag;
    cmdIf.afu_tlx_cmd_bdf    = bdf;
    cmdIf.afu_tlx_cmd_pasid  = pasid;
    tblClr = tclr;
    errClr = eclr;
    reset  = rst;
    modelCycle(v, op, tag, bdf, pasid, tclr, eclr, rst);
    @(posedge clock);
    #1;
  endtask

  task automatic cmdStep(input logic [7:0] op, input logic [11:0] tag,
                         input logic [15:0] bdf, input logic [19:0] pasid);
    applyStimulus(1'b1, op, tag, bdf, pasid, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 8'h00, 12'h000, 16'h0, 20'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 8'h00, 12'h000, 16'h0, 20'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 12'h000, 16'h0, 20'h0, 1'b0, 1'b0, 1'b1);
    idleStep();
  endtask

  // Reset drives every output to zero.
  task automatic test_reset();
    cfgBase = 12'h100;
    applyStimulus(1'b0, 8'h00, 12'h000, 16'h0, 20'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 12'h000, 16'h0, 20'h0, 1'b0, 1'b0, 1'b1);
    testCount++;
    if (actualResult() !== 41'd0) begin
      failCount++;
      $display("[TB] FAIL reset_result got %h required %h", actualResult(), 41'd0);
    end
    testCount++;
    if (actualStatus() !== 27'd0) begin
      failCount++;
      $display("[TB] FAIL reset_status got %h required %h", actualStatus(), 27'd0);
    end
  endtask

  // Assign then use of the same acTag resolves to the assigned BDF/PASID.
  task automatic test_resolve();
    cfgBase = 12'h100;
    resetDut();
    cmdStep(8'h50, 12'h103, 16'h1A2B, 20'h00042);
    cmdStep(8'h20, 12'h103, 16'h0, 20'h0);
    testCount++;
    if (actualResult() !== expResult || chk_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL resolve_assign got %h required %h", actualResult(), expResult);
    end
    idleStep();
    testCount++;
    if ({chk_valid, chk_err, chk_bdf, chk_pasid} !== {1'b1, 1'b0, 16'h1A2B, 20'h00042}) begin
      failCount++;
      $display("[TB] FAIL resolve_use got %h required %h",
               {chk_valid, chk_err, chk_bdf, chk_pasid}, {1'b1, 1'b0, 16'h1A2B, 20'h00042});
    end
    testCount++;
    if (actualResult() !== expResult) begin
      failCount++;
      $display("[TB] FAIL resolve_model got %h required %h", actualResult(), expResult);
    end
  endtask

  // Use of an in-range acTag that was never assigned.
  task automatic test_unassigned();
    cfgBase = 12'h100;
    resetDut();
    cmdStep(8'h10, 12'h105, 16'h0, 20'h0);
    idleStep();
    testCount++;
    if ({chk_valid, chk_err, chk_err_code} !== {1'b1, 1'b1, 2'b01}) begin
      failCount++;
      $display("[TB] FAIL unassigned_err got %b required %b",
               {chk_valid, chk_err, chk_err_code}, {1'b1, 1'b1, 2'b01});
    end
    testCount++;
    if (actualStatus() !== {4'd1, 1'b1, 8'h10, 12'h105, 2'b01}) begin
      failCount++;
      $display("[TB] FAIL unassigned_cap got %h required %h",
               actualStatus(), {4'd1, 1'b1, 8'h10, 12'h105, 2'b01});
    end
  endtask

  // Out-of-range assign above the window and use just below the base.
  task automatic test_range();
    cfgBase = 12'h100;
    resetDut();
    cmdStep(8'h50, 12'h110, 16'h5555, 20'h55555);
    cmdStep(8'h10, 12'h0FF, 16'h0, 20'h0);
    testCount++;
    if ({chk_valid, chk_err, chk_err_code} !== {1'b0, 1'b1, 2'b10}) begin
      failCount++;
      $display("[TB] FAIL range_assign got %b required %b",
               {chk_valid, chk_err, chk_err_code}, {1'b0, 1'b1, 2'b10});
    end
    idleStep();
    testCount++;
    if ({chk_valid, chk_err, chk_err_code, chk_bdf} !== {1'b1, 1'b1, 2'b10, 16'h0}) begin
      failCount++;
      $display("[TB] FAIL range_use got %h required %h",
               {chk_valid, chk_err, chk_err_code, chk_bdf}, {1'b1, 1'b1, 2'b10, 16'h0});
    end
    testCount++;
    if (actualStatus() !== {4'd2, 1'b1, 8'h50, 12'h110, 2'b10}) begin
      failCount++;
      $display("[TB] FAIL range_cap got %h required %h",
               actualStatus(), {4'd2, 1'b1, 8'h50, 12'h110, 2'b10});
    end
  endtask

  // Second assign to a valid entry pulses chk_reassign and replaces the data.
  task automatic test_reassign();
    cfgBase = 12'h100;
    resetDut();
    cmdStep(8'h50, 12'h102, 16'h0BEE, 20'h00001);
    cmdStep(8'h50, 12'h102, 16'h0BEE, 20'h00002);
    testCount++;
    if (chk_reassign !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reassign_first got %b required %b", chk_reassign, 1'b0);
    end
    cmdStep(8'h12, 12'h102, 16'h0, 20'h0);
    testCount++;
    if ({chk_reassign, chk_err} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL reassign_second got %b required %b", {chk_reassign, chk_err}, 2'b10);
    end
    idleStep();
    testCount++;
    if ({chk_valid, chk_err, chk_pasid} !== {1'b1, 1'b0, 20'h00002}) begin
      failCount++;
      $display("[TB] FAIL reassign_use got %h required %h",
               {chk_valid, chk_err, chk_pasid}, {1'b1, 1'b0, 20'h00002});
    end
  endtask

  // Table clear racing with assigns: the newer assign survives, older
  // entries are gone.
  task automatic test_table_clr();
    cfgBase = 12'h100;
    resetDut();
    cmdStep(8'h50, 12'h100, 16'h1111, 20'h11111);
    idleStep();
    idleStep();
    applyStimulus(1'b1, 8'h50, 12'h101, 16'h2222, 20'h22222, 1'b1, 1'b0, 1'b0);
    cmdStep(8'h10, 12'h100, 16'h0, 20'h0);
    cmdStep(8'h10, 12'h101, 16'h0, 20'h0);
    testCount++;
    if ({chk_valid, chk_err, chk_err_code} !== {1'b1, 1'b1, 2'b01}) begin
      failCount++;
      $display("[TB] FAIL tblclr_old got %b required %b",
               {chk_valid, chk_err, chk_err_code}, {1'b1, 1'b1, 2'b01});
    end
    idleStep();
    testCount++;
    if ({chk_valid, chk_err, chk_bdf, chk_pasid} !== {1'b1, 1'b0, 16'h2222, 20'h22222}) begin
      failCount++;
      $display("[TB] FAIL tblclr_new got %h required %h",
               {chk_valid, chk_err, chk_bdf, chk_pasid}, {1'b1, 1'b0, 16'h2222, 20'h22222});
    end
    cmdStep(8'h50, 12'h103, 16'h3333, 20'h33333);
    applyStimulus(1'b0, 8'h00, 12'h000, 16'h0, 20'h0, 1'b1, 1'b0, 1'b0);
    cmdStep(8'h20, 12'h103, 16'h0, 20'h0);
    idleStep();
    testCount++;
    if ({chk_valid, chk_err, chk_bdf, chk_pasid} !== {1'b1, 1'b0, 16'h3333, 20'h33333}) begin
      failCount++;
      $display("[TB] FAIL tblclr_coincident got %h required %h",
               {chk_valid, chk_err, chk_bdf, chk_pasid}, {1'b1, 1'b0, 16'h3333, 20'h33333});
    end
  endtask

  // Counter saturation and the error clear racing with an error.
  task automatic test_saturation();
    cfgBase = 12'h100;
    resetDut();
    for (int i = 0; i < 16; i++) begin
      cmdStep(8'h10, 12'h105, 16'h0, 20'h0);
      testCount++;
      if (actualStatus() !== expStatus) begin
        failCount++;
        $display("[TB] FAIL sat_model got %h required %h", actualStatus(), expStatus);
      end
    end
    idleStep();
    testCount++;
    if (actualStatus() !== {4'hF, 1'b1, 8'h10, 12'h105, 2'b01}) begin
      failCount++;
      $display("[TB] FAIL sat_hold got %h required %h",
               actualStatus(), {4'hF, 1'b1, 8'h10, 12'h105, 2'b01});
    end
    cmdStep(8'h28, 12'h107, 16'h0, 20'h0);
    applyStimulus(1'b0, 8'h00, 12'h000, 16'h0, 20'h0, 1'b0, 1'b1, 1'b0);
    testCount++;
    if ({chk_err, actualStatus()} !== {1'b1, 4'd1, 1'b1, 8'h28, 12'h107, 2'b01}) begin
      failCount++;
      $display("[TB] FAIL errclr_coincident got %h required %h",
               {chk_err, actualStatus()}, {1'b1, 4'd1, 1'b1, 8'h28, 12'h107, 2'b01});
    end
    applyStimulus(1'b0, 8'h00, 12'h000, 16'h0, 20'h0, 1'b0, 1'b1, 1'b0);
    testCount++;
    if ({chk_err_cnt, chk_cap_held} !== {4'd0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL errclr_plain got %h required %h",
               {chk_err_cnt, chk_cap_held}, {4'd0, 1'b0});
    end
  endtask

  // A reset arriving with commands in flight discards them.
  task automatic test_reset_midstream();
    cfgBase = 12'h100;
    resetDut();
    cmdStep(8'h50, 12'h104, 16'h4444, 20'h44444);
    applyStimulus(1'b1, 8'h10, 12'h104, 16'h0, 20'h0, 1'b0, 1'b0, 1'b1);
    testCount++;
    if (actualResult() !== 41'd0) begin
      failCount++;
      $display("[TB] FAIL midrst_flush got %h required %h", actualResult(), 41'd0);
    end
    idleStep();
    testCount++;
    if ({actualResult(), actualStatus()} !== 68'd0) begin
      failCount++;
      $display("[TB] FAIL midrst_drain got %h required %h", {actualResult(), actualStatus()}, 68'd0);
    end
    cmdStep(8'h10, 12'h104, 16'h0, 20'h0);
    idleStep();
    testCount++;
    if ({chk_valid, chk_err, chk_err_code} !== {1'b1, 1'b1, 2'b01}) begin
      failCount++;
      $display("[TB] FAIL midrst_nowrite got %b required %b",
               {chk_valid, chk_err, chk_err_code}, {1'b1, 1'b1, 2'b01});
    end
  endtask

  // Random traffic around the acTag window, including a base that makes the
  // window wrap through acTag 0, checked against the model every cycle.
  task automatic test_random();
    logic [11:0] bases [2];
    logic [7:0]  useOps [6];
    bases[0] = 12'h100;
    bases[1] = 12'hFFA;
    useOps[0] = 8'h10; useOps[1] = 8'h12; useOps[2] = 8'h20;
    useOps[3] = 8'h28; useOps[4] = 8'h30; useOps[5] = 8'h58;
    for (int b = 0; b < 2; b++) begin
      cfgBase = bases[b];
      resetDut();
      for (int c = 0; c < 150; c++) begin
        logic        v;
        logic [7:0]  op;
        logic [11:0] tag;
        int          r;
        v   = ($urandom_range(0, 7) != 0);
        r   = int'($urandom_range(0, 9));
        op  = (r < 3) ? 8'h50 : (r < 9) ? useOps[r - 3] : 8'($urandom);
        tag = cfgBase + 12'($urandom_range(0, 19)) - 12'd2;
        applyStimulus(v, op, tag, 16'($urandom), 20'($urandom),
                      ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), 1'b0);
        testCount++;
        if (actualResult() !== expResult) begin
          failCount++;
          $display("[TB] FAIL random_result got %h required %h", actualResult(), expResult);
        end
        testCount++;
        if (actualStatus() !== expStatus) begin
          failCount++;
          $display("[TB] FAIL random_status got %h required %h", actualStatus(), expStatus);
        end
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    testCount = 0;
    failCount = 0;
    reset   = 1'b1;
    cfgBase = 12'h000;
    tblClr  = 1'b0;
    errClr  = 1'b0;
    cmdIf.afu_tlx_cmd_valid  = 1'b0;
    cmdIf.afu_tlx_cmd_opcode = 8'h00;
    cmdIf.afu_tlx_cmd_actag  = 12'h000;
    cmdIf.afu_tlx_cmd_bdf    = 16'h0;
    cmdIf.afu_tlx_cmd_pasid  = 20'h0;
    pV = 1'b0; pOp = '0; pTag = '0; pBdf = '0; pPasid = '0;
    test_reset();
    test_resolve();
    test_unassigned();
    test_range();
    test_reassign();
    test_table_clr();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
